// File: rtl/mem_access_if.sv
// Core-to-memory bus: request/response handshake plus the imem program-load port.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_i_ou_d;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;

  // Core / loader side
  modport master (
    output req_valid, req_i_ou_d, req_write, req_addr, req_wdata,
    output prog_we, prog_addr, prog_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory unit side
  modport slave (
    input  req_valid, req_i_ou_d, req_write, req_addr, req_wdata,
    input  prog_we, prog_addr, prog_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory front-end for the multicycle RV32 core: instruction RAM and data RAM behind a
// single-outstanding valid/ready request port with programmable wait states.
module mem_access_unit #(
  parameter int unsigned IMEM_WORDS  = 1024,
  parameter int unsigned DMEM_WORDS  = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_access_if.slave  bus
);

  localparam int unsigned IMEM_AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DMEM_AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int unsigned AW      = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;

  typedef enum logic [2:0] {StIdle, StWait, StAccess, StResp, StErr} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          write_q;
  logic          i_ou_d_q;

  logic [31:0]   imem [IMEM_WORDS];
  logic [31:0]   dmem [DMEM_WORDS];

  logic          accept;
  logic          illegal;
  logic          prog_ok;
  logic [31:0]   req_word;
  logic [31:0]   prog_word;

  assign req_word  = {2'b00, bus.req_addr[31:2]};
  assign prog_word = {2'b00, bus.prog_addr[31:2]};
  assign accept    = (state_q == StIdle) && bus.req_valid;

  // Legality of the presented request, evaluated against the current inputs
  always_comb begin
    illegal = 1'b0;
    if (bus.req_addr[1:0] != 2'b00)                   illegal = 1'b1;
    if (!bus.req_i_ou_d && bus.req_write)             illegal = 1'b1;
    if (!bus.req_i_ou_d && req_word >= IMEM_WORDS)    illegal = 1'b1;
    if (bus.req_i_ou_d && req_word >= DMEM_WORDS)     illegal = 1'b1;
  end

  // Misaligned or out-of-range program writes are dropped
  assign prog_ok = bus.prog_we && (bus.prog_addr[1:0] == 2'b00) && (prog_word < IMEM_WORDS);

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and handshake/response outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = rdata_q;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (illegal) begin
            state_d = StErr;
          end else if (WAIT_CYCLES == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: state_d = StResp;
      StResp: begin
        bus.rsp_valid = 1'b1;
        state_d       = StIdle;
      end
      StErr: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Request capture and read-data register; an error response reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      write_q  <= 1'b0;
      i_ou_d_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      if (accept) begin
        idx_q    <= bus.req_addr[AW+1:2];
        wdata_q  <= bus.req_wdata;
        write_q  <= bus.req_write;
        i_ou_d_q <= bus.req_i_ou_d;
        if (illegal) rdata_q <= 32'd0;
      end
      if (state_q == StAccess && !write_q) begin
        rdata_q <= i_ou_d_q ? dmem[idx_q[DMEM_AW-1:0]] : imem[idx_q[IMEM_AW-1:0]];
      end
    end
  end

  // RAM writes; non-blocking update gives read-before-write against the fetch above
  always_ff @(posedge clk) begin
    if (state_q == StAccess && write_q && i_ou_d_q) dmem[idx_q[DMEM_AW-1:0]] <= wdata_q;
    if (prog_ok) imem[bus.prog_addr[IMEM_AW+1:2]] <= bus.prog_wdata;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit: one instance with one wait state,
// one with none.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if bus_w1 ();
  mem_access_if bus_w0 ();

  mem_access_unit #(.WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(bus_w1));
  mem_access_unit #(.WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst_n(rst_n), .bus(bus_w0));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rdata [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // d = 0 selects the one-wait-state unit, d = 1 the zero-wait-state unit
  task automatic set_req(input int d, input bit v, input bit iod, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (d == 0) begin
      bus_w1.req_valid = v; bus_w1.req_i_ou_d = iod; bus_w1.req_write = wr;
      bus_w1.req_addr = addr; bus_w1.req_wdata = wd;
    end else begin
      bus_w0.req_valid = v; bus_w0.req_i_ou_d = iod; bus_w0.req_write = wr;
      bus_w0.req_addr = addr; bus_w0.req_wdata = wd;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? bus_w1.req_ready : bus_w0.req_ready;
  endfunction
  function automatic logic get_valid(input int d);
    return (d == 0) ? bus_w1.rsp_valid : bus_w0.rsp_valid;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? bus_w1.rsp_err : bus_w0.rsp_err;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? bus_w1.rsp_rdata : bus_w0.rsp_rdata;
  endfunction

  task automatic prog(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_w1.prog_we = 1'b1; bus_w1.prog_addr = addr; bus_w1.prog_wdata = data;
    bus_w0.prog_we = 1'b1; bus_w0.prog_addr = addr; bus_w0.prog_wdata = data;
    @(negedge clk);
    bus_w1.prog_we = 1'b0;
    bus_w0.prog_we = 1'b0;
  endtask

  // Called just after the accept edge; counts cycles until rsp_valid (bounded)
  task automatic wait_rsp(input int d, input string tag);
    exp_t e;
    int   n;
    bit   got;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = get_valid(d);
    end
    e = sb.pop_front();
    check({tag, " latency"}, 32'(n), 32'(e.lat));
    check({tag, " err"}, 32'(get_err(d)), 32'(e.err));
    check({tag, " rdata"}, get_rdata(d), e.rdata);
  endtask

  task automatic issue(input int d, input bit iod, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] load_val, input bit err,
                       input string tag);
    exp_t e;
    e.err   = err;
    e.rdata = err ? 32'd0 : (wr ? last_rdata[d] : load_val);
    e.lat   = err ? 1 : ((d == 0) ? 3 : 2);
    last_rdata[d] = e.rdata;
    sb.push_back(e);
    @(negedge clk);
    set_req(d, 1'b1, iod, wr, addr, wd);
    check({tag, " ready"}, 32'(get_ready(d)), 32'd1);
    @(posedge clk);
    #1 set_req(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp(d, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus_w1.prog_we = 1'b0; bus_w1.prog_addr = 32'd0; bus_w1.prog_wdata = 32'd0;
    bus_w0.prog_we = 1'b0; bus_w0.prog_addr = 32'd0; bus_w0.prog_wdata = 32'd0;
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
    #12;
    check("reset ready", 32'(bus_w1.req_ready), 32'd1);
    check("reset valid", 32'(bus_w1.rsp_valid), 32'd0);
    check("reset err", 32'(bus_w1.rsp_err), 32'd0);
    check("reset rdata", bus_w1.rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Program load and first fetch
    prog(32'h0, 32'h0050_0093);
    issue(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0050_0093, 1'b0, "fetch0");

    // Store then load back
    issue(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "store10");
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "load10");

    // Reset while a store sits in WAIT
    issue(0, 1'b1, 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0, "store20");
    issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, "load20");
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h2222_2222);
    @(posedge clk);
    #1 set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async rst ready", 32'(bus_w1.req_ready), 32'd1);
    check("async rst valid", 32'(bus_w1.rsp_valid), 32'd0);
    check("async rst rdata", bus_w1.rsp_rdata, 32'd0);
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, "load20 after rst");

    // Illegal requests leave memory untouched
    issue(0, 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "misaligned");
    issue(0, 1'b0, 1'b1, 32'h0, 32'hBAD0_BAD0, 32'h0, 1'b1, "imem write");
    issue(0, 1'b1, 1'b1, 32'h11, 32'hBAD1_BAD1, 32'h0, 1'b1, "misaligned store");
    issue(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0050_0093, 1'b0, "fetch0 kept");
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "load10 kept");
    issue(0, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, "dmem range");
    issue(0, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, "imem range");

    // Dropped program writes must not alias onto word 0
    prog(32'h1001, 32'hAAAA_AAAA);
    prog(32'h1000, 32'hBBBB_BBBB);
    issue(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0050_0093, 1'b0, "prog dropped");

    // Program write during the fetch's ACCESS cycle: fetch sees the old word
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    bus_w1.prog_we = 1'b1; bus_w1.prog_addr = 32'h0; bus_w1.prog_wdata = 32'h1234_5678;
    @(negedge clk);
    bus_w1.prog_we = 1'b0;
    check("rbw valid", 32'(bus_w1.rsp_valid), 32'd1);
    check("rbw rdata", bus_w1.rsp_rdata, 32'h0050_0093);
    last_rdata[0] = 32'h0050_0093;
    issue(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, "fetch after rbw");

    // Zero wait states
    issue(1, 1'b1, 1'b1, 32'h4, 32'hCAFE_F00D, 32'h0, 1'b0, "w0 store");
    issue(1, 1'b1, 1'b0, 32'h4, 32'h0, 32'hCAFE_F00D, 1'b0, "w0 load");
    issue(1, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, "w0 range");

    // Continuous req_valid: IDLE, WAIT, ACCESS, RESP repeating
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) begin
        e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; e.lat = 0;
        sb.push_back(e);
      end
      check($sformatf("stream ready k=%0d", k), 32'(bus_w1.req_ready), 32'(k % 4 == 0));
      check($sformatf("stream valid k=%0d", k), 32'(bus_w1.rsp_valid), 32'(k % 4 == 3));
      if (bus_w1.rsp_valid) begin
        e = sb.pop_front();
        check($sformatf("stream rdata k=%0d", k), bus_w1.rsp_rdata, e.rdata);
        check($sformatf("stream err k=%0d", k), 32'(bus_w1.rsp_err), 32'(e.err));
      end
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("stream drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
